// File: rtl/uart_pkg.sv
// UART shared definitions: receiver state encoding and data width, reused by the future transmitter.
// Latency: none (declarations only).
// Backpressure: none (declarations only). Macro UART_RX_PARITY_EN adds the parity state.
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        RX_IDLE      = 3'd0,
        RX_START     = 3'd1,
        RX_DATA      = 3'd2,
`ifdef UART_RX_PARITY_EN
        RX_PARITY    = 3'd3,
`endif
        RX_STOP      = 3'd4,
        RX_WAIT_IDLE = 3'd5
    } rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer bringing an asynchronous level into the clk domain.
// Latency: 2 clk cycles from d to q.
// Backpressure: none; q simply follows d.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic meta;

    // Two back-to-back flops; reset to the line's idle value so no false edge appears.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_8n1.sv
// UART receiver, 8 data bits LSB first, 1 stop bit; optional even parity with macro UART_RX_PARITY_EN.
// Latency: byte visible on data_out/rx_valid the edge the stop bit is sampled (mid stop bit + 3 cycles).
// Backpressure: none on the line; an unacknowledged byte is overwritten and overrun_err is set.
module uart_rx_8n1
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rx,
    input  logic       rx_ack,
`ifdef UART_RX_PARITY_EN
    output logic       parity_err,
`endif
    output logic [UART_DATA_BITS-1:0] data_out,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       overrun_err,
    output logic       busy
);

    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] T_HALF = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);

    localparam logic [2:0] S_IDLE      = RX_IDLE;
    localparam logic [2:0] S_START     = RX_START;
    localparam logic [2:0] S_DATA      = RX_DATA;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] S_PARITY    = RX_PARITY;
    localparam logic [2:0] S_AFTER_DAT = RX_PARITY;
`else
    localparam logic [2:0] S_AFTER_DAT = RX_STOP;
`endif
    localparam logic [2:0] S_STOP      = RX_STOP;
    localparam logic [2:0] S_WAIT_IDLE = RX_WAIT_IDLE;

    logic [2:0]                state;
    logic [TW-1:0]             timer;
    logic [2:0]                bit_idx;
    logic [UART_DATA_BITS-1:0] shift_q;
    logic                      rx_s;
    logic                      rx_prev;
    logic                      byte_done;
    logic                      par_bad;

    sync_2ff #(.RST_VAL(1'b1)) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (rx),
        .q       (rx_s)
    );

`ifndef UART_RX_PARITY_EN
    assign par_bad = 1'b0;
`endif

    // A good stop bit with no parity failure completes a byte this cycle.
    assign byte_done = (state == S_STOP) && (timer == T_LAST) && rx_s && !par_bad;
    assign busy      = (state != S_IDLE);

    // Frame state machine: edge detect, mid-bit sampling, shift register and error pulses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            timer      <= '0;
            bit_idx    <= '0;
            shift_q    <= '0;
            rx_prev    <= 1'b1;
            frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
            par_bad    <= 1'b0;
`endif
        end else begin
            rx_prev    <= rx_s;
            frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    if (rx_prev && !rx_s) begin
                        timer <= '0;
                        state <= S_START;
                    end
                end
                S_START: begin
                    if (timer == T_HALF) begin
                        timer <= '0;
                        if (rx_s) begin
                            state <= S_IDLE;
                        end else begin
                            bit_idx <= '0;
                            state   <= S_DATA;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                S_DATA: begin
                    if (timer == T_LAST) begin
                        timer   <= '0;
                        shift_q <= {rx_s, shift_q[UART_DATA_BITS-1:1]};
                        if (bit_idx == 3'd7) begin
                            state <= S_AFTER_DAT;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (timer == T_LAST) begin
                        timer      <= '0;
                        // Even parity: data ones plus parity bit must be even.
                        par_bad    <= (^shift_q) ^ rx_s;
                        parity_err <= (^shift_q) ^ rx_s;
                        state      <= S_STOP;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
`endif
                S_STOP: begin
                    if (timer == T_LAST) begin
                        timer <= '0;
                        if (rx_s) begin
                            state <= S_IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= S_WAIT_IDLE;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                S_WAIT_IDLE: begin
                    // Hold off until the line returns high so a break cannot start a frame.
                    if (rx_s) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Output holding register: new byte wins over acknowledge; overwrite of an unread byte is sticky.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_out    <= '0;
            rx_valid    <= 1'b0;
            overrun_err <= 1'b0;
        end else if (byte_done) begin
            data_out    <= shift_q;
            rx_valid    <= 1'b1;
            overrun_err <= (rx_valid && !rx_ack) ? 1'b1 :
                           (rx_valid &&  rx_ack) ? 1'b0 : overrun_err;
        end else if (rx_valid && rx_ack) begin
            rx_valid    <= 1'b0;
            overrun_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx_8n1.sv
// Bench for uart_rx_8n1 at 16 clocks per bit; directed scenarios plus random frames vs a byte-level model.
// Latency: frames driven at bit rate; outputs sampled 1 time unit after the active edge.
// Backpressure: rx_ack driven by the bench; model tracks valid/overrun at whole-frame granularity.
module tb_uart_rx_8n1;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       rx = 1'b1;
    logic       rx_ack = 1'b0;
    logic [7:0] data_out;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun_err;
    logic       busy;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
`endif

    int checks = 0;
    int failures = 0;
    int ferr_cnt = 0;
    int perr_cnt = 0;

    // Byte-level reference: what the consumer should see after each whole frame.
    logic [7:0] exp_data = 8'h00;
    logic       exp_valid = 1'b0;
    logic       exp_ovr = 1'b0;

    always #5 clk = ~clk;

    uart_rx_8n1 #(.CLKS_PER_BIT(CPB)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .rx          (rx),
        .rx_ack      (rx_ack),
`ifdef UART_RX_PARITY_EN
        .parity_err  (parity_err),
`endif
        .data_out    (data_out),
        .rx_valid    (rx_valid),
        .frame_err   (frame_err),
        .overrun_err (overrun_err),
        .busy        (busy)
    );

    // Count error pulses (cycles high) seen at the falling edge.
    always @(negedge clk) begin
        if (frame_err) ferr_cnt <= ferr_cnt + 1;
`ifdef UART_RX_PARITY_EN
        if (parity_err) perr_cnt <= perr_cnt + 1;
`endif
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_model(input string tag);
        check({tag, "_data"}, 32'(data_out), 32'(exp_data));
        check({tag, "_valid"}, 32'(rx_valid), 32'(exp_valid));
        check({tag, "_ovr"}, 32'(overrun_err), 32'(exp_ovr));
    endtask

    task automatic ack();
        rx_ack = 1'b1;
        tick(1);
        rx_ack = 1'b0;
        if (exp_valid) begin
            exp_valid = 1'b0;
            exp_ovr   = 1'b0;
        end
    endtask

    // One frame; par_flip corrupts the parity bit when parity is compiled in.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic par_flip);
        logic good;
        good = stop_bit;
        rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(CPB);
        end
`ifdef UART_RX_PARITY_EN
        rx = (^b) ^ par_flip;
        tick(CPB);
        if (par_flip) good = 1'b0;
`endif
        rx = stop_bit;
        tick(4);
        check("pre_stop_data", 32'(data_out), 32'(exp_data));
        check("pre_stop_valid", 32'(rx_valid), 32'(exp_valid));
        tick(CPB - 4);
        if (good) begin
            if (exp_valid) exp_ovr = 1'b1;
            exp_data  = b;
            exp_valid = 1'b1;
        end
    endtask

    initial begin
        int fe0;
        int pe0;
        int waited;
        logic [7:0] rb;
        logic       rstop;

        // Reset state
        tick(3);
        check("rst_data", 32'(data_out), 32'h00);
        check("rst_valid", 32'(rx_valid), 32'h0);
        check("rst_ferr", 32'(frame_err), 32'h0);
        check("rst_ovr", 32'(overrun_err), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        reset_n = 1'b1;
        tick(2 * CPB);
        check("idle_after_rst", 32'(busy), 32'h0);

        // Clean frame 0xA5
        fe0 = ferr_cnt;
        send_frame(8'hA5, 1'b1, 1'b0);
        tick(1);
        check_model("a5");
        check("a5_value", 32'(data_out), 32'hA5);
        check("a5_ferr", 32'(ferr_cnt - fe0), 32'd0);
        ack();
        check("a5_ack_valid", 32'(rx_valid), 32'h0);

        // False start: 5-cycle low glitch
        rx = 1'b0;
        tick(5);
        rx = 1'b1;
        check("glitch_busy", 32'(busy), 32'h1);
        waited = 0;
        while (busy && waited < 10) begin
            tick(1);
            waited++;
        end
        check("glitch_idle", 32'(busy), 32'h0);
        tick(2 * CPB);
        check("glitch_still_idle", 32'(busy), 32'h0);
        check_model("glitch");

        // Bad stop bit followed by a break
        fe0 = ferr_cnt;
        send_frame(8'h3C, 1'b0, 1'b0);
        tick(40);
        check("break_busy", 32'(busy), 32'h1);
        check("break_ferr_cnt", 32'(ferr_cnt - fe0), 32'd1);
        check_model("break");
        rx = 1'b1;
        waited = 0;
        while (busy && waited < 10) begin
            tick(1);
            waited++;
        end
        check("break_release", 32'(busy), 32'h0);
        tick(2 * CPB);
        check("break_no_retrigger", 32'(busy), 32'h0);
        check("break_ferr_final", 32'(ferr_cnt - fe0), 32'd1);

        // Overrun: two bytes, no acknowledge
        send_frame(8'h11, 1'b1, 1'b0);
        send_frame(8'h22, 1'b1, 1'b0);
        tick(1);
        check_model("ovr");
        check("ovr_value", 32'(data_out), 32'h22);
        check("ovr_flag", 32'(overrun_err), 32'h1);
        ack();
        check_model("ovr_ack");

        // Reset in the middle of bit 4 of 0xFF, then a clean 0x81
        rx = 1'b0;
        tick(CPB);
        rx = 1'b1;
        tick(4 * CPB + CPB / 2);
        reset_n = 1'b0;
        tick(2);
        check("midrst_data", 32'(data_out), 32'h00);
        check("midrst_busy", 32'(busy), 32'h0);
        check("midrst_valid", 32'(rx_valid), 32'h0);
        exp_data = 8'h00; exp_valid = 1'b0; exp_ovr = 1'b0;
        reset_n = 1'b1;
        tick(3 * CPB);
        check("midrst_idle", 32'(busy), 32'h0);
        fe0 = ferr_cnt;
        send_frame(8'h81, 1'b1, 1'b0);
        tick(1);
        check_model("after_rst");
        check("after_rst_value", 32'(data_out), 32'h81);
        check("after_rst_ferr", 32'(ferr_cnt - fe0), 32'd0);
        ack();

`ifdef UART_RX_PARITY_EN
        // Wrong parity on 0x07
        pe0 = perr_cnt;
        send_frame(8'h07, 1'b1, 1'b1);
        tick(1);
        check("par_cnt", 32'(perr_cnt - pe0), 32'd1);
        check_model("par");
`else
        pe0 = perr_cnt;
`endif

        // Random frames with random acknowledges, gaps and occasional bad stop bits
        for (int k = 0; k < 10; k++) begin
            rb    = 8'($urandom);
            rstop = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 1) == 1) ack();
            tick($urandom_range(0, 20));
            fe0 = ferr_cnt;
            send_frame(rb, rstop, 1'b0);
            if (!rstop) begin
                tick(CPB);
                rx = 1'b1;
                tick(8);
            end
            tick(1);
            check_model("rand");
            check("rand_ferr", 32'(ferr_cnt - fe0), rstop ? 32'd0 : 32'd1);
        end
        check("perr_total", 32'(perr_cnt - pe0), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx_8n1.md
UART_RX_8N1 -- requirements
Module: uart_rx_8n1

Interface
REQ-001 Parameter CLKS_PER_BIT, default 868, SHALL set the clk cycles per bit (100 MHz / 115200); legal range is 4 or more.
REQ-002 Port clk, input, 1 bit, SHALL be the single clock; all state updates on posedge clk.
REQ-003 Port reset_n, input, 1 bit, SHALL be the reset: asynchronous, active-low.
REQ-004 Port rx, input, 1 bit, SHALL be the asynchronous serial line; idle level is 1.
REQ-005 Port rx_ack, input, 1 bit, SHALL be the consumer acknowledge that clears rx_valid.
REQ-006 Port data_out, output, 8 bits, SHALL carry the last correctly received byte.
REQ-007 Port rx_valid, output, 1 bit, SHALL be high while an unacknowledged byte is held in data_out.
REQ-008 Port frame_err, output, 1 bit, SHALL pulse high for one cycle when a stop bit samples 0.
REQ-009 Port overrun_err, output, 1 bit, SHALL be a sticky flag: a byte completed while rx_valid was already high.
REQ-010 Port busy, output, 1 bit, SHALL be high in every state except IDLE.

Function
REQ-011 rx SHALL pass through a 2-flop synchronizer before any use; this adds 2 cycles of latency.
REQ-012 The FSM SHALL have states IDLE, START, DATA, STOP and WAIT_IDLE, plus PARITY when the parity feature is compiled in.
REQ-013 IDLE: a synchronized 1->0 transition SHALL clear the bit-timer and move the FSM to START.
REQ-014 START: the line SHALL be sampled at timer = CLKS_PER_BIT/2 - 1 (floor).
REQ-015 START sample = 1 (false start) SHALL return the FSM to IDLE with no outputs changed.
REQ-016 START sample = 0 SHALL reset the timer and enter DATA.
REQ-017 DATA: 8 bits SHALL be sampled LSB first, each at timer = CLKS_PER_BIT-1, shifted right into a shift register, tracked by a 3-bit index that ends at 7.
REQ-018 STOP: the stop bit SHALL be sampled at timer = CLKS_PER_BIT-1.
REQ-019 STOP sample = 1 SHALL load data_out from the shift register and set rx_valid on the next edge, then return the FSM to IDLE.
REQ-020 STOP sample = 0 SHALL pulse frame_err, leave data_out and rx_valid unchanged, and enter WAIT_IDLE.
REQ-021 WAIT_IDLE SHALL stay until the synchronized rx = 1 and then go to IDLE, so a break condition never retriggers.
REQ-022 rx_ack high SHALL clear rx_valid on the next edge.
REQ-023 rx_ack is ignored while rx_valid = 0.
REQ-024 A byte completing while rx_valid = 1 and rx_ack = 0 SHALL overwrite data_out, keep rx_valid = 1 and set overrun_err.
REQ-025 A byte completing in the same cycle as rx_ack SHALL take priority: rx_valid stays 1, data_out takes the new byte, no overrun.
REQ-026 overrun_err SHALL clear on rx_ack unless REQ-024 fires in the same cycle.
REQ-027 The bit-timer SHALL be $clog2(CLKS_PER_BIT) bits wide and wrap to 0 after each sample point.

Reset
REQ-028 reset_n = 0 SHALL immediately set state = IDLE, the synchronizer flops = 1, and timer, index and shift register = 0.
REQ-029 Under reset, outputs SHALL be data_out = 8'h00 and rx_valid, frame_err, overrun_err, busy = 0.
REQ-030 Reset asserted mid-frame SHALL discard the partial byte.
REQ-031 After reset release, the FSM SHALL wait for a fresh 1->0 transition before starting a frame.

Configuration
REQ-032 Macro UART_RX_PARITY_EN defined SHALL insert a PARITY state between DATA and STOP that samples an even-parity bit.
REQ-033 With UART_RX_PARITY_EN defined, output parity_err (1 bit) SHALL pulse for one cycle on mismatch, data_out SHALL not load, and the FSM continues to STOP.
REQ-034 UART_RX_PARITY_EN undefined SHALL leave no PARITY state and no parity_err port (8N1 framing).

Structure
REQ-035 Package uart_pkg SHALL hold the rx_state_t enum and the constant UART_DATA_BITS = 8, shared with the future transmitter.
REQ-036 The synchronizer SHALL be a sub-module sync_2ff (clk, reset_n, d, q) with reset value parameterised to 1.

Verification (CLKS_PER_BIT = 16)
REQ-037 Send frame 0x A5 (start, bits 1,0,1,0,0,1,0,1, stop) -> rx_valid rises after the stop-bit mid-sample, data_out = 8'hA5, frame_err = 0.
REQ-038 Pulse rx low for 5 cycles only -> false start; FSM back in IDLE, rx_valid stays 0, busy drops within 10 cycles.
REQ-039 Send 0x3C with stop bit = 0, then hold rx low for 40 cycles, then release -> one frame_err pulse, data_out unchanged, FSM leaves WAIT_IDLE only after rx = 1.
REQ-040 Send 0x11 then 0x22 with no rx_ack -> data_out = 8'h22, overrun_err = 1; rx_ack then clears both rx_valid and overrun_err.
REQ-041 Assert reset_n = 0 during bit 4 of 0xFF, release, then send 0x81 -> data_out = 8'h81, no error flags.
REQ-042 With UART_RX_PARITY_EN, send 0x07 with parity bit = 0 -> one parity_err pulse, rx_valid stays 0.
